mc_sequencer: RTL and testbench

Parametrised multicycle control sequencer for the MIPS-subset datapath. It is the successor to the fixed-timing control unit.
- Adds a configurable memory wait-state count.
- Adds a start/done handshake to the mult/div unit.
- Adds precise exception entry (invalid opcode, overflow, divide-by-zero) via EPC and a byte-wide vector table.

It sits between the IR opcode/funct fields and every datapath mux/write-enable.

---
 rtl/mc_sequencer_if.sv | 38 +++
 rtl/mc_sequencer.sv | 245 ++++++++++++++++++++++++
 tb/tb_mc_sequencer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_sequencer_if.sv
// Control bundle between the multicycle sequencer and the MIPS-subset datapath:
// instruction fields and status flags in, mux selects and write strobes out.
interface mc_sequencer_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       overflow;
    logic       div_zero;
    logic       md_done;
    logic       mem_rd;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [1:0] iord;
    logic [7:0] exc_addr;
    logic       epc_write;
    logic [1:0] alu_src_a;
    logic [2:0] alu_src_b;
    logic [2:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       md_start;
    logic       md_sel;
    logic [5:0] state_out;

    modport master (
        input  opcode, funct, overflow, div_zero, md_done,
        output mem_rd, ir_write, pc_write, pc_src, iord, exc_addr, epc_write,
               alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, md_start, md_sel,
               state_out
    );

    modport slave (
        output opcode, funct, overflow, div_zero, md_done,
        input  mem_rd, ir_write, pc_write, pc_src, iord, exc_addr, epc_write,
               alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, md_start, md_sel,
               state_out
    );
endinterface

// File: rtl/mc_sequencer.sv
// Multicycle control sequencer: memory wait states, mult/div handshake and
// precise exception entry through EPC and a byte-wide vector table.
module mc_sequencer #(
    parameter int         MEM_WAIT  = 2,
    parameter bit         ENABLE_MD = 1'b1,
    parameter logic [7:0] VEC_OPC   = 8'd253,
    parameter logic [7:0] VEC_OVF   = 8'd254,
    parameter logic [7:0] VEC_DIV0  = 8'd255
) (
    input  logic           clk,
    input  logic           reset,
    mc_sequencer_if.master bus
);

    typedef enum logic [5:0] {
        RST      = 6'd0,  FETCH   = 6'd1,  IR_LOAD = 6'd2,  DECODE  = 6'd3,
        EXEC_R   = 6'd4,  WB_R    = 6'd5,  EXEC_I  = 6'd6,  WB_I    = 6'd7,
        BEQ      = 6'd8,  JUMP    = 6'd9,  MD_START = 6'd10, MD_WAIT = 6'd11,
        EXC_EPC  = 6'd12, EXC_RD  = 6'd13, EXC_PC  = 6'd14
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0, CAUSE_OPC = 2'd1, CAUSE_OVF = 2'd2, CAUSE_DIV0 = 2'd3
    } cause_t;

    typedef struct packed {
        logic       mem_rd;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic [1:0] iord;
        logic [7:0] exc_addr;
        logic       epc_write;
        logic [1:0] alu_src_a;
        logic [2:0] alu_src_b;
        logic [2:0] alu_op;
        logic       reg_write;
        logic       reg_dst;
        logic       md_start;
        logic       md_sel;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] FN_ADD    = 6'h20;
    localparam logic [5:0] FN_SUB    = 6'h22;
    localparam logic [5:0] FN_AND    = 6'h24;
    localparam logic [5:0] FN_MULT   = 6'h18;
    localparam logic [5:0] FN_DIV    = 6'h1a;
    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    function automatic logic [7:0] vector_for(input cause_t c);
        case (c)
            CAUSE_OVF:  return VEC_OVF;
            CAUSE_DIV0: return VEC_DIV0;
            default:    return VEC_OPC;
        endcase
    endfunction

    function automatic logic [2:0] r_alu_op(input logic [5:0] fn);
        case (fn)
            FN_SUB:  return 3'b010;
            FN_AND:  return 3'b011;
            default: return 3'b001;
        endcase
    endfunction

    // Control word a state presents; evaluated on the next state so it can be registered.
    function automatic ctrl_t decode_ctrl(input state_t st, input cause_t c, input logic [5:0] fn);
        ctrl_t ctl;
        ctl = '0;
        case (st)
            FETCH:    ctl.mem_rd = 1'b1;
            IR_LOAD:  begin
                ctl.ir_write  = 1'b1;
                ctl.pc_write  = 1'b1;
                ctl.alu_src_b = 3'b001;
                ctl.alu_op    = 3'b001;
            end
            DECODE:   begin
                ctl.alu_src_b = 3'b011;
                ctl.alu_op    = 3'b001;
            end
            EXEC_R:   begin
                ctl.alu_src_a = 2'b01;
                ctl.alu_op    = r_alu_op(fn);
            end
            WB_R:     begin
                ctl.reg_write = 1'b1;
                ctl.reg_dst   = 1'b1;
            end
            EXEC_I:   begin
                ctl.alu_src_a = 2'b01;
                ctl.alu_src_b = 3'b010;
                ctl.alu_op    = 3'b001;
            end
            WB_I:     ctl.reg_write = 1'b1;
            BEQ:      begin
                ctl.pc_src    = 2'b01;
                ctl.alu_src_a = 2'b01;
                ctl.alu_op    = 3'b010;
            end
            JUMP:     begin
                ctl.pc_write = 1'b1;
                ctl.pc_src   = 2'b10;
            end
            MD_START: begin
                ctl.md_start = 1'b1;
                ctl.md_sel   = fn[1];
            end
            EXC_EPC:  begin
                ctl.epc_write = 1'b1;
                ctl.alu_src_b = 3'b001;
                ctl.alu_op    = 3'b010;
            end
            EXC_RD:   begin
                ctl.mem_rd   = 1'b1;
                ctl.iord     = 2'b10;
                ctl.exc_addr = vector_for(c);
            end
            EXC_PC:   begin
                ctl.pc_write = 1'b1;
                ctl.pc_src   = 2'b11;
            end
            default:  ctl = '0;
        endcase
        return ctl;
    endfunction

    state_t     state_r, state_nxt_s;
    cause_t     cause_r, cause_nxt_s;
    logic [3:0] wait_cnt_r, wait_cnt_nxt_s;
    ctrl_t      ctrl_r, ctrl_nxt_s;

    // Next-state, wait counter, exception cause and next control word.
    always_comb begin
        state_nxt_s    = state_r;
        cause_nxt_s    = cause_r;
        wait_cnt_nxt_s = wait_cnt_r;
        case (state_r)
            RST:      state_nxt_s = FETCH;
            FETCH, EXC_RD: begin
                if (wait_cnt_r == WAIT_LAST) begin
                    state_nxt_s    = (state_r == FETCH) ? IR_LOAD : EXC_PC;
                    wait_cnt_nxt_s = 4'd0;
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r + 4'd1;
                end
            end
            IR_LOAD:  state_nxt_s = DECODE;
            DECODE: begin
                if (bus.opcode == OP_RTYPE) begin
                    if ((bus.funct == FN_ADD) || (bus.funct == FN_SUB) || (bus.funct == FN_AND)) begin
                        state_nxt_s = EXEC_R;
                    end else if (ENABLE_MD && ((bus.funct == FN_MULT) || (bus.funct == FN_DIV))) begin
                        state_nxt_s = MD_START;
                    end else begin
                        state_nxt_s = EXC_EPC;
                        cause_nxt_s = CAUSE_OPC;
                    end
                end else begin
                    case (bus.opcode)
                        OP_ADDI: state_nxt_s = EXEC_I;
                        OP_BEQ:  state_nxt_s = BEQ;
                        OP_J:    state_nxt_s = JUMP;
                        default: begin
                            state_nxt_s = EXC_EPC;
                            cause_nxt_s = CAUSE_OPC;
                        end
                    endcase
                end
            end
            EXEC_R: begin
                if (bus.overflow && (bus.funct != FN_AND)) begin
                    state_nxt_s = EXC_EPC;
                    cause_nxt_s = CAUSE_OVF;
                end else begin
                    state_nxt_s = WB_R;
                end
            end
            EXEC_I: begin
                if (bus.overflow) begin
                    state_nxt_s = EXC_EPC;
                    cause_nxt_s = CAUSE_OVF;
                end else begin
                    state_nxt_s = WB_I;
                end
            end
            WB_R, WB_I, BEQ, JUMP, EXC_PC: state_nxt_s = FETCH;
            MD_START: begin
                if (bus.funct[1] && bus.div_zero) begin
                    state_nxt_s = EXC_EPC;
                    cause_nxt_s = CAUSE_DIV0;
                end else begin
                    state_nxt_s = MD_WAIT;
                end
            end
            MD_WAIT: begin
                if (bus.md_done) begin
                    state_nxt_s = FETCH;
                end else begin
                    state_nxt_s = MD_WAIT;
                end
            end
            EXC_EPC:  state_nxt_s = EXC_RD;
            default:  state_nxt_s = RST;
        endcase
        ctrl_nxt_s = decode_ctrl(state_nxt_s, cause_nxt_s, bus.funct);
    end

    // State, counter, cause and registered control outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= RST;
            cause_r    <= CAUSE_NONE;
            wait_cnt_r <= 4'd0;
            ctrl_r     <= '0;
        end else begin
            state_r    <= state_nxt_s;
            cause_r    <= cause_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
            ctrl_r     <= ctrl_nxt_s;
        end
    end

    assign bus.mem_rd    = ctrl_r.mem_rd;
    assign bus.ir_write  = ctrl_r.ir_write;
    assign bus.pc_write  = ctrl_r.pc_write;
    assign bus.pc_src    = ctrl_r.pc_src;
    assign bus.iord      = ctrl_r.iord;
    assign bus.exc_addr  = ctrl_r.exc_addr;
    assign bus.epc_write = ctrl_r.epc_write;
    assign bus.alu_src_a = ctrl_r.alu_src_a;
    assign bus.alu_src_b = ctrl_r.alu_src_b;
    assign bus.alu_op    = ctrl_r.alu_op;
    assign bus.reg_write = ctrl_r.reg_write;
    assign bus.reg_dst   = ctrl_r.reg_dst;
    assign bus.md_sel    = ctrl_r.md_sel;
    assign bus.state_out = state_r;
    // div_zero only becomes valid once MD_START is occupied, so the start pulse is masked live.
    assign bus.md_start  = ctrl_r.md_start & ~(ctrl_r.md_sel & bus.div_zero);

endmodule

// File: tb/tb_mc_sequencer.sv
// Table-driven bench for mc_sequencer: one MEM_WAIT=2 instance with mult/div,
// one MEM_WAIT=0 instance without, plus hand-written mult/div and reset sequences.
module tb_mc_sequencer;

    typedef struct packed {
        logic [5:0] state;
        logic       mem_rd;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic [1:0] iord;
        logic [7:0] exc_addr;
        logic       epc_write;
        logic [1:0] alu_src_a;
        logic [2:0] alu_src_b;
        logic [2:0] alu_op;
        logic       reg_write;
        logic       reg_dst;
        logic       md_start;
        logic       md_sel;
    } exp_t;

    typedef struct {
        bit         b;
        logic       rst;
        logic [5:0] op;
        logic [5:0] fn;
        logic       ov;
        logic       dz;
        logic       md;
        exp_t       e;
    } vec_t;

    // Expected outputs per state (state, mem_rd, ir_write, pc_write, pc_src, iord, exc_addr,
    // epc_write, alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, md_start, md_sel).
    localparam exp_t X_RST  = '{6'd0,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 8'd0,   1'b0, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam exp_t X_FET  = '{6'd1,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 8'd0,   1'b0, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam exp_t X_IRL  = '{6'd2,  1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 8'd0,   1'b0, 2'b00, 3'b001, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam exp_t X_DEC  = '{6'd3,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 8'd0,   1'b0, 2'b00, 3'b011, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam exp_t X_ADD  = '{6'd4,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 8'd0,   1'b0, 2'b01, 3'b000, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam exp_t X_SUB  = '{6'd4,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 8'd0,   1'b0, 2'b01, 3'b000, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam exp_t X_AND  = '{6'd4,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 8'd0,   1'b0, 2'b01, 3'b000, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam exp_t X_WBR  = '{6'd5,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 8'd0,   1'b0, 2'b00, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam exp_t X_EXI  = '{6'd6,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 8'd0,   1'b0, 2'b01, 3'b010, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam exp_t X_WBI  = '{6'd7,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 8'd0,   1'b0, 2'b00, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam exp_t X_BEQ  = '{6'd8,  1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 8'd0,   1'b0, 2'b01, 3'b000, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam exp_t X_JMP  = '{6'd9,  1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 8'd0,   1'b0, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam exp_t X_MUL  = '{6'd10, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 8'd0,   1'b0, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam exp_t X_DIV  = '{6'd10, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 8'd0,   1'b0, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam exp_t X_DIVZ = '{6'd10, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 8'd0,   1'b0, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam exp_t X_MDW  = '{6'd11, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 8'd0,   1'b0, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam exp_t X_EPC  = '{6'd12, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 8'd0,   1'b1, 2'b00, 3'b001, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam exp_t X_V253 = '{6'd13, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 8'd253, 1'b0, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam exp_t X_V254 = '{6'd13, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 8'd254, 1'b0, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam exp_t X_V255 = '{6'd13, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 8'd255, 1'b0, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam exp_t X_XPC  = '{6'd14, 1'b0, 1'b0, 1'b1, 2'b11, 2'b00, 8'd0,   1'b0, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mc_sequencer_if bus_a ();
    mc_sequencer_if bus_b ();

    mc_sequencer #(.MEM_WAIT(2), .ENABLE_MD(1'b1)) dut_a (.clk(clk), .reset(rst_n), .bus(bus_a));
    mc_sequencer #(.MEM_WAIT(0), .ENABLE_MD(1'b0)) dut_b (.clk(clk), .reset(rst_n), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t       tbl[$];
    bit         cur_b;
    logic [5:0] cur_op;
    logic [5:0] cur_fn;

    function automatic exp_t get_out(input bit b);
        exp_t r;
        if (b) begin
            r = '{bus_b.state_out, bus_b.mem_rd, bus_b.ir_write, bus_b.pc_write, bus_b.pc_src,
                  bus_b.iord, bus_b.exc_addr, bus_b.epc_write, bus_b.alu_src_a, bus_b.alu_src_b,
                  bus_b.alu_op, bus_b.reg_write, bus_b.reg_dst, bus_b.md_start, bus_b.md_sel};
        end else begin
            r = '{bus_a.state_out, bus_a.mem_rd, bus_a.ir_write, bus_a.pc_write, bus_a.pc_src,
                  bus_a.iord, bus_a.exc_addr, bus_a.epc_write, bus_a.alu_src_a, bus_a.alu_src_b,
                  bus_a.alu_op, bus_a.reg_write, bus_a.reg_dst, bus_a.md_start, bus_a.md_sel};
        end
        return r;
    endfunction

    task automatic chk(input string name, input exp_t act, input exp_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: state got %0d want %0d, outputs got %h want %h",
                     name, act.state, exp.state, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic v(input logic ov, input logic dz, input logic md, input exp_t e);
        vec_t r;
        r.b = cur_b; r.rst = 1'b1; r.op = cur_op; r.fn = cur_fn;
        r.ov = ov; r.dz = dz; r.md = md; r.e = e;
        tbl.push_back(r);
    endtask

    task automatic rst_rec();
        vec_t r;
        r.b = cur_b; r.rst = 1'b0; r.op = cur_op; r.fn = cur_fn;
        r.ov = 1'b0; r.dz = 1'b0; r.md = 1'b0; r.e = X_RST;
        tbl.push_back(r);
    endtask

    // Remaining fetch cycles of a MEM_WAIT=2 instruction, then IR_LOAD and DECODE.
    task automatic fetch_a(input logic [5:0] op, input logic [5:0] fn, input logic md);
        cur_op = op;
        cur_fn = fn;
        v(1'b0, 1'b0, md,   X_FET);
        v(1'b0, 1'b0, 1'b0, X_FET);
        v(1'b0, 1'b0, 1'b0, X_IRL);
        v(1'b0, 1'b0, 1'b0, X_DEC);
    endtask

    task automatic drive(input vec_t r);
        rst_n = r.rst;
        if (r.b) begin
            bus_b.opcode = r.op; bus_b.funct = r.fn; bus_b.overflow = r.ov;
            bus_b.div_zero = r.dz; bus_b.md_done = r.md;
        end else begin
            bus_a.opcode = r.op; bus_a.funct = r.fn; bus_a.overflow = r.ov;
            bus_a.div_zero = r.dz; bus_a.md_done = r.md;
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_a(input logic [5:0] op, input logic [5:0] fn, input logic dz);
        bus_a.opcode = op; bus_a.funct = fn; bus_a.overflow = 1'b0;
        bus_a.div_zero = dz; bus_a.md_done = 1'b0;
    endtask

    initial begin
        int starts;
        int not_waiting;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        set_a(6'h00, 6'h00, 1'b0);
        bus_b.opcode = 6'h00; bus_b.funct = 6'h00; bus_b.overflow = 1'b0;
        bus_b.div_zero = 1'b0; bus_b.md_done = 1'b0;

        // Instance A (MEM_WAIT=2, mult/div enabled)
        cur_b = 1'b0; cur_op = 6'h00; cur_fn = 6'h00;
        rst_rec(); rst_rec();
        v(1'b0, 1'b0, 1'b0, X_FET);
        fetch_a(6'h00, 6'h20, 1'b1);                       // add, stray md_done in FETCH
        v(1'b0, 1'b0, 1'b0, X_ADD); v(1'b0, 1'b0, 1'b0, X_WBR); v(1'b0, 1'b0, 1'b0, X_FET);
        fetch_a(6'h00, 6'h22, 1'b0);                       // sub with overflow
        v(1'b0, 1'b0, 1'b0, X_SUB); v(1'b1, 1'b0, 1'b0, X_EPC);
        v(1'b0, 1'b0, 1'b0, X_V254); v(1'b0, 1'b0, 1'b0, X_V254); v(1'b0, 1'b0, 1'b0, X_V254);
        v(1'b0, 1'b0, 1'b0, X_XPC); v(1'b0, 1'b0, 1'b0, X_FET);
        fetch_a(6'h3f, 6'h00, 1'b0);                       // invalid opcode
        v(1'b0, 1'b0, 1'b0, X_EPC);
        v(1'b0, 1'b0, 1'b0, X_V253); v(1'b0, 1'b0, 1'b0, X_V253); v(1'b0, 1'b0, 1'b0, X_V253);
        v(1'b0, 1'b0, 1'b0, X_XPC); v(1'b0, 1'b0, 1'b0, X_FET);
        fetch_a(6'h08, 6'h00, 1'b0);                       // addi with overflow
        v(1'b0, 1'b0, 1'b0, X_EXI); v(1'b1, 1'b0, 1'b0, X_EPC);
        v(1'b0, 1'b0, 1'b0, X_V254); v(1'b0, 1'b0, 1'b0, X_V254); v(1'b0, 1'b0, 1'b0, X_V254);
        v(1'b0, 1'b0, 1'b0, X_XPC); v(1'b0, 1'b0, 1'b0, X_FET);
        fetch_a(6'h08, 6'h00, 1'b0);                       // addi, no overflow
        v(1'b0, 1'b0, 1'b0, X_EXI); v(1'b0, 1'b0, 1'b0, X_WBI); v(1'b0, 1'b0, 1'b0, X_FET);
        fetch_a(6'h00, 6'h24, 1'b0);                       // and ignores overflow
        v(1'b0, 1'b0, 1'b0, X_AND); v(1'b1, 1'b0, 1'b0, X_WBR); v(1'b0, 1'b0, 1'b0, X_FET);
        fetch_a(6'h04, 6'h00, 1'b0);                       // beq
        v(1'b0, 1'b0, 1'b0, X_BEQ); v(1'b0, 1'b0, 1'b0, X_FET);
        fetch_a(6'h02, 6'h00, 1'b0);                       // jump
        v(1'b0, 1'b0, 1'b0, X_JMP); v(1'b0, 1'b0, 1'b0, X_FET);
        fetch_a(6'h00, 6'h1a, 1'b0);                       // div by zero
        v(1'b0, 1'b1, 1'b0, X_DIVZ); v(1'b0, 1'b1, 1'b0, X_EPC);
        v(1'b0, 1'b0, 1'b0, X_V255); v(1'b0, 1'b0, 1'b0, X_V255); v(1'b0, 1'b0, 1'b0, X_V255);
        v(1'b0, 1'b0, 1'b0, X_XPC); v(1'b0, 1'b0, 1'b0, X_FET);
        fetch_a(6'h00, 6'h18, 1'b0);                       // mult ignores div_zero
        v(1'b0, 1'b1, 1'b0, X_MUL); v(1'b0, 1'b1, 1'b0, X_MDW);
        v(1'b0, 1'b0, 1'b0, X_MDW); v(1'b0, 1'b0, 1'b1, X_FET);

        // Instance B (MEM_WAIT=0, mult/div disabled): mult is an invalid opcode
        cur_b = 1'b1; cur_op = 6'h00; cur_fn = 6'h18;
        rst_rec();
        v(1'b0, 1'b0, 1'b0, X_FET); v(1'b0, 1'b0, 1'b0, X_IRL); v(1'b0, 1'b0, 1'b0, X_DEC);
        v(1'b0, 1'b0, 1'b0, X_EPC); v(1'b0, 1'b0, 1'b0, X_V253); v(1'b0, 1'b0, 1'b0, X_XPC);
        v(1'b0, 1'b0, 1'b0, X_FET); v(1'b0, 1'b0, 1'b0, X_IRL);

        @(negedge clk);
        foreach (tbl[i]) begin
            drive(tbl[i]);
            step();
            chk($sformatf("vec%0d", i), get_out(tbl[i].b), tbl[i].e);
        end

        // div with a long mult/div latency: single start pulse, FETCH right after md_done
        set_a(6'h00, 6'h1a, 1'b0);
        do_reset();
        starts = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            starts += int'(bus_a.md_start);
        end
        step();
        chk("div_md_start", get_out(1'b0), X_DIV);
        starts += int'(bus_a.md_start);
        not_waiting = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            starts += int'(bus_a.md_start);
            if (bus_a.state_out !== 6'd11) not_waiting++;
        end
        chk_int("md_wait_hold", not_waiting, 0);
        bus_a.md_done = 1'b1;
        step();
        bus_a.md_done = 1'b0;
        chk("md_done_fetch", get_out(1'b0), X_FET);
        chk_int("md_start_pulses", starts, 1);

        // asynchronous reset while waiting on mult/div
        set_a(6'h00, 6'h18, 1'b0);
        do_reset();
        for (int i = 0; i < 6; i++) step();
        step();
        chk("mult_wait", get_out(1'b0), X_MDW);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", get_out(1'b0), X_RST);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("post_reset_fetch%0d", i), get_out(1'b0), X_FET);
        end
        step();
        chk("post_reset_ir_load", get_out(1'b0), X_IRL);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
